mem_port: RTL and testbench
===========================

# mem_port

Bus-master sequencer on the CPU side of the memory interface: accepts one load/store request at a time through a valid/ready handshake and drives MemWrite/MemMode/memAddr/memWriteData into the external memory system, capturing memReadData. The memory system writes only whole words to RAM, so byte stores to RAM (0x1xxx) are done as read-modify-write. Byte stores to I/O (0xFxxx) are single writes. Sits between the multicycle controller/datapath and the external memory.

## Interface
- WIDTH, 32, data width
- ADDR_WIDTH, 16, byte address width; region = addr[15:12]
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  3  000 LW, 001 LB, 010 LBU, 100 SW, 101 SB; others illegal
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  WIDTH  store data; SB uses [7:0]
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_err  out  1  valid with resp_valid
- resp_rdata  out  WIDTH  load result, held until next response
- MemWrite  out  1  memory write strobe
- MemMode  out  2  00 word, 01 signed byte, 10 unsigned byte
- memAddr  out  ADDR_WIDTH  memory address
- memWriteData  out  WIDTH  memory write data
- memReadData  in  WIDTH  combinational read data from memory

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: on req_valid, latch op/addr/wdata, then decode:
  - error (illegal op; region not 0x0/0x1/0xF; any store to region 0x0) -> RESP, resp_err=1, no memory access
  - loads -> RD
  - SW, or SB to 0xF -> WR
  - SB to 0x1 -> RMW_RD
- RD: memAddr=addr; MemMode=00 (LW), 01 (LB), or 10 (LBU); capture memReadData into resp_rdata at end of cycle -> RESP.
- WR: MemWrite=1, memAddr=addr. memWriteData is wdata for SW, {24'b0,wdata[7:0]} for SB to I/O -> RESP.
- RMW_RD: MemMode=00, memAddr=addr; capture word -> RMW_WR.
- RMW_WR: MemWrite=1; memWriteData = captured word with lane addr[1:0] (bits 8*lane+7:8*lane) replaced by wdata[7:0] -> RESP.
- RESP: resp_valid=1 -> IDLE. resp_rdata is unchanged for stores and errors.
- Outside RD/RMW_RD: MemMode=00. Outside WR/RMW_WR: MemWrite=0. memAddr holds the last latched address.
- MemWrite = (state is WR or RMW_WR) & ~reset.

## Timing
- Request accepted at edge k (req_valid & req_ready).
- Load: RD in cycle k+1; resp_valid in k+2 with data.
- SW / SB to I/O: write in k+1; resp_valid in k+2.
- SB to RAM: read in k+1, write in k+2, resp_valid in k+3.
- Error: resp_valid in k+1; no MemWrite pulse.
- Each write produces exactly one MemWrite-high cycle.
- req_valid during a non-IDLE state is ignored; the requester holds it until req_ready.
- Reset values: state IDLE, req_ready 1 after reset deasserts, resp_valid 0, resp_err 0, resp_rdata 0, MemWrite 0, MemMode 00, memAddr 0, memWriteData 0.
- Reset mid-operation (including RMW_WR): MemWrite goes low in the reset cycle, the pending request is dropped with no response, and the FSM returns to IDLE.

## Configuration
- MEMPORT_ALIGN_CHECK_EN defined: LW/SW with addr[1:0]≠0 is an error (resp_err=1, response at k+1, no access).
- Undefined: word accesses clear addr[1:0] to 00 on memAddr and proceed normally.
- Byte ops are never alignment-checked.

## Structure
- Package mem_port_pkg: op encodings, state enum, MemMode constants (MM_WORD, MM_SBYTE, MM_UBYTE), region constants (REGION_ROM=4'h0, REGION_RAM=4'h1, REGION_IO=4'hF).
- Sub-module byte_lane_merge (combinational): inputs old word, byte, lane; output merged word. Used in RMW_WR.
- Top holds the FSM, request latches, and response registers.

## Test plan
- RAM 0x1000 preloaded 0x11223344. LW 0x1000 -> resp_valid at k+2, rdata 0x11223344, err 0.
- LB 0x1003 on word 0x80FF0000 -> rdata 0xFFFFFF80. LBU 0x1002 -> rdata 0x000000FF.
- SB 0x1001 data 0xAB onto 0x11223344 -> reads at k+1, one MemWrite at k+2 with data 0x1122AB44, resp at k+3. A following LW returns 0x1122AB44.
- SB 0xFFFC data 0x5A -> one MemWrite at k+1 with data 0x0000005A, no read cycle. SW 0x0004 -> err 1, no MemWrite. LW 0x2000 -> err 1.
- With MEMPORT_ALIGN_CHECK_EN, LW 0x1002 -> err 1 at k+1. Without it, memAddr=0x1000 and the word is returned.
- Reset asserted during RMW_WR -> MemWrite 0 that cycle, no resp_valid, req_ready 1 after reset deasserts. Back-to-back requests are each accepted only in IDLE.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared encodings for the mem_port bus-master sequencer: request opcodes,
// FSM states, MemMode values and address-region codes.
package mem_port_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  localparam logic [1:0] MM_WORD  = 2'b00;
  localparam logic [1:0] MM_SBYTE = 2'b01;
  localparam logic [1:0] MM_UBYTE = 2'b10;

  localparam logic [3:0] REGION_ROM = 4'h0;
  localparam logic [3:0] REGION_RAM = 4'h1;
  localparam logic [3:0] REGION_IO  = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  // MemMode the memory should use while servicing a load opcode
  function automatic logic [1:0] load_mode(input logic [2:0] op);
    case (op)
      OP_LB:   load_mode = MM_SBYTE;
      OP_LBU:  load_mode = MM_UBYTE;
      default: load_mode = MM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_byte_lane_merge.sv
// byte_lane_merge: replaces one byte lane of a word with a new byte.
// Used to build the write-back word of a RAM byte store (read-modify-write).
module byte_lane_merge #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [7:0]       new_byte,
  input  logic [1:0]       lane,
  output logic [WIDTH-1:0] merged
);

  // keep every lane of the old word except the addressed one
  always_comb begin
    merged = old_word;
    merged[8*lane +: 8] = new_byte;
  end

endmodule

// File: rtl/mem_port.sv
// mem_port: one-at-a-time load/store sequencer driving the external memory.
// Byte stores to RAM are done as read-modify-write because RAM only takes
// whole words; byte stores to I/O are single writes.
// Optional build macro MEMPORT_ALIGN_CHECK_EN: when defined, misaligned
// LW/SW are rejected with resp_err; otherwise their low address bits are
// cleared and the access proceeds.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  MemWrite,
  output logic [1:0]            MemMode,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0]      memWriteData,
  input  logic [WIDTH-1:0]      memReadData
);

  state_t                state;
  logic                  mem_write_q;
  logic [7:0]            wbyte_q;
  logic [1:0]            lane_q;
  logic [3:0]            region;
  logic                  is_load, is_store, is_word, region_ok, misalign, is_err;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [WIDTH-1:0]      merged;

  assign region    = req_addr[ADDR_WIDTH-1 -: 4];
  assign req_ready = (state == IDLE);
  // the write strobe is killed in the very cycle reset is asserted
  assign MemWrite  = mem_write_q & ~reset;

  // decode the incoming request: legality, region checks and effective address
  always_comb begin
    is_load   = (req_op == OP_LW) || (req_op == OP_LB) || (req_op == OP_LBU);
    is_store  = (req_op == OP_SW) || (req_op == OP_SB);
    is_word   = (req_op == OP_LW) || (req_op == OP_SW);
    region_ok = (region == REGION_ROM) || (region == REGION_RAM) || (region == REGION_IO);
    misalign  = 1'b0;
    eff_addr  = req_addr;
`ifdef MEMPORT_ALIGN_CHECK_EN
    misalign  = is_word && (req_addr[1:0] != 2'b00);
`else
    if (is_word) eff_addr[1:0] = 2'b00;
`endif
    is_err = !(is_load || is_store) || !region_ok ||
             (is_store && (region == REGION_ROM)) || misalign;
  end

  byte_lane_merge #(.WIDTH(WIDTH)) u_merge (
    .old_word (memReadData),
    .new_byte (wbyte_q),
    .lane     (lane_q),
    .merged   (merged)
  );

  // sequencer FSM with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      mem_write_q  <= 1'b0;
      MemMode      <= MM_WORD;
      memAddr      <= '0;
      memWriteData <= '0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      wbyte_q      <= '0;
      lane_q       <= '0;
    end else begin
      resp_valid  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            memAddr <= eff_addr;
            wbyte_q <= req_wdata[7:0];
            lane_q  <= req_addr[1:0];
            if (is_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= RESP;
            end else if (is_load) begin
              MemMode <= load_mode(req_op);
              state   <= RD;
            end else if ((req_op == OP_SW) || (region == REGION_IO)) begin
              mem_write_q  <= 1'b1;
              memWriteData <= (req_op == OP_SW) ? req_wdata
                                                : {{(WIDTH-8){1'b0}}, req_wdata[7:0]};
              state        <= WR;
            end else begin
              MemMode <= MM_WORD;
              state   <= RMW_RD;
            end
          end
        end
        RD: begin
          resp_rdata <= memReadData;
          MemMode    <= MM_WORD;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RMW_RD: begin
          memWriteData <= merged;
          mem_write_q  <= 1'b1;
          state        <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Testbench for mem_port: word-array memory model, directed request vectors,
// and queues of expected responses / writes checked by a negedge monitor.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        MemWrite;
  logic [1:0]  MemMode;
  logic [15:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  mem_port #(.WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .MemWrite(MemWrite), .MemMode(MemMode), .memAddr(memAddr),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: whole-word writes, byte extraction/extension on read
  logic [31:0] mem [0:16383];
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  always_comb begin
    rd_word = mem[memAddr[15:2]];
    rd_byte = rd_word[8*memAddr[1:0] +: 8];
    case (MemMode)
      2'b01:   memReadData = {{24{rd_byte[7]}}, rd_byte};
      2'b10:   memReadData = {24'h0, rd_byte};
      default: memReadData = rd_word;
    endcase
  end
  always @(posedge clk) if (MemWrite) mem[memAddr[15:2]] <= memWriteData;

  typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } resp_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; int acc; int lat; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int total = 0;
  int bad = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare every response and every write strobe against the queues
  always @(negedge clk) begin
    resp_t r;
    wr_t   w;
    if (resp_valid === 1'b1) begin
      if (rq.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
      else begin
        r = rq.pop_front();
        check("resp_err", {31'h0, resp_err}, {31'h0, r.err});
        check("resp_rdata", resp_rdata, r.rdata);
        check("resp_latency", cyc - r.acc + 1, r.lat);
      end
    end
    if (MemWrite === 1'b1) begin
      if (wq.size() == 0) check("write_unexpected", 32'd1, 32'd0);
      else begin
        w = wq.pop_front();
        check("write_addr", {16'h0, memAddr}, {16'h0, w.addr});
        check("write_data", memWriteData, w.data);
        check("write_latency", cyc - w.acc + 1, w.lat);
      end
    end
  end

  // present a request and wait (bounded) until it is accepted
  task automatic present(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // issue a request and queue the expected response (and write, if any)
  task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] ld_data, input int lat,
                       input logic wr, input logic [15:0] waddr, input logic [31:0] wd,
                       input int wlat, input logic chk_maddr, input logic [15:0] maddr);
    resp_t r;
    wr_t   w;
    present(op, addr, wdata);
    if (!err && op[2] == 1'b0) last_rdata = ld_data;
    r.err = err; r.rdata = last_rdata; r.acc = cyc; r.lat = lat;
    rq.push_back(r);
    if (wr) begin
      w.addr = waddr; w.data = wd; w.acc = cyc; w.lat = wlat;
      wq.push_back(w);
    end
    if (chk_maddr) check("memAddr_aligned", {16'h0, memAddr}, {16'h0, maddr});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin @(negedge clk); n++; end
    check("drain_resp_queue", rq.size(), 0);
    check("drain_write_queue", wq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[16'h1000 >> 2] = 32'h11223344;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'h0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_MemWrite", {31'h0, MemWrite}, 32'd0);
    check("rst_MemMode", {30'h0, MemMode}, 32'd0);
    check("rst_memAddr", {16'h0, memAddr}, 32'd0);
    check("rst_memWriteData", memWriteData, 32'h0);

    //    op      addr      wdata         err  load data     lat wr  waddr     wdata         wl chk maddr
    issue(3'b000, 16'h1000, 32'h0,        0, 32'h11223344, 2, 0, 16'h0,    32'h0,        0, 1, 16'h1000);
    issue(3'b101, 16'h1001, 32'h000000AB, 0, 32'h0,        3, 1, 16'h1001, 32'h1122AB44, 2, 0, 16'h0);
    issue(3'b000, 16'h1000, 32'h0,        0, 32'h1122AB44, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b100, 16'h1000, 32'h80FF0000, 0, 32'h0,        2, 1, 16'h1000, 32'h80FF0000, 1, 0, 16'h0);
    issue(3'b001, 16'h1003, 32'h0,        0, 32'hFFFFFF80, 2, 0, 16'h0,    32'h0,        0, 1, 16'h1003);
    issue(3'b010, 16'h1002, 32'h0,        0, 32'h000000FF, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b101, 16'hFFFC, 32'h1234565A, 0, 32'h0,        2, 1, 16'hFFFC, 32'h0000005A, 1, 0, 16'h0);
    issue(3'b100, 16'h0004, 32'h55555555, 1, 32'h0,        1, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b000, 16'h2000, 32'h0,        1, 32'h0,        1, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b011, 16'h1000, 32'h0,        1, 32'h0,        1, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b101, 16'h0000, 32'h000000AA, 1, 32'h0,        1, 0, 16'h0,    32'h0,        0, 0, 16'h0);
`ifdef MEMPORT_ALIGN_CHECK_EN
    issue(3'b000, 16'h1002, 32'h0,        1, 32'h0,        1, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b100, 16'h1006, 32'hDEADBEEF, 1, 32'h0,        1, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b000, 16'h1004, 32'h0,        0, 32'h00000000, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
`else
    issue(3'b000, 16'h1002, 32'h0,        0, 32'h80FF0000, 2, 0, 16'h0,    32'h0,        0, 1, 16'h1000);
    issue(3'b100, 16'h1006, 32'hDEADBEEF, 0, 32'h0,        2, 1, 16'h1004, 32'hDEADBEEF, 1, 0, 16'h0);
    issue(3'b000, 16'h1004, 32'h0,        0, 32'hDEADBEEF, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
`endif
    issue(3'b101, 16'h1003, 32'h00000033, 0, 32'h0,        3, 1, 16'h1003, 32'h33FF0000, 2, 0, 16'h0);
    issue(3'b010, 16'h1003, 32'h0,        0, 32'h00000033, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b001, 16'h1000, 32'h0,        0, 32'h00000000, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    drain();

    // reset while the RAM byte store is in its write cycle: nothing may land
    present(3'b101, 16'h1001, 32'h00000077);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_midop_MemWrite", {31'h0, MemWrite}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rdata = 32'h0;
    check("rst_midop_req_ready", {31'h0, req_ready}, 32'd1);
    check("rst_midop_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_midop_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    check("rst_midop_no_resp", {31'h0, resp_valid}, 32'd0);

    issue(3'b000, 16'h1000, 32'h0,        0, 32'h33FF0000, 2, 0, 16'h0,    32'h0,        0, 0, 16'h0);
    issue(3'b101, 16'hF001, 32'h000000C3, 0, 32'h0,        2, 1, 16'hF001, 32'h000000C3, 1, 0, 16'h0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
